// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter that moves at most STEP bits per cycle,
// with valid/ready handshakes on the request and result sides.
module seq_shifter #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = $clog2(XLEN),
  parameter int STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [XLEN-1:0]    operand,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               busy
);

  // k only ever ranges over 0..STEP, so the per-cycle shifter stays STEP wide.
  localparam int KW = $clog2(STEP + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_SLL = 2'd0,
    OP_SRL = 2'd1,
    OP_SRA = 2'd2,
    OP_ROR = 2'd3
  } op_t;

  state_t             state_q, state_d;
  op_t                op_q;
  logic [SHAMT_W-1:0] rem_q;
  logic [XLEN-1:0]    acc_q;

  logic [KW-1:0]      k;
  logic [SHAMT_W-1:0] rem_step;
  logic [XLEN-1:0]    acc_step;
  logic               accept;

  assign accept = in_valid & in_ready;
  assign result = acc_q;

  // One step of the iterative shift. Since k <= rem, no bits carry between steps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    acc_step = acc_q;
    if (int'(rem_q) >= STEP) k = KW'(STEP);
    else                     k = KW'(rem_q);
    rem_step = rem_q - SHAMT_W'(k);
    case (op_q)
      OP_SLL:  acc_step = acc_q << k;
      OP_SRL:  acc_step = acc_q >> k;
      OP_SRA:  acc_step = XLEN'($signed(acc_q) >>> k);
      OP_ROR:  acc_step = (acc_q >> k) | (acc_q << (XLEN - int'(k)));
      default: acc_step = acc_q;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (accept) state_d = (shamt == '0) ? S_DONE : S_SHIFT;
        S_SHIFT: if (rem_step == '0) state_d = S_DONE;
        S_DONE:  if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: acc is reset because result is directly visible and must read 0 out of reset.
    if (rst) begin
      op_q  <= OP_SLL;
      rem_q <= '0;
      acc_q <= '0;
    end else if (flush) begin
      // The partial acc is left in place; only the remaining count is cleared.
      rem_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            acc_q <= operand;
            op_q  <= op_t'(op);
            rem_q <= shamt;
          end
        end
        S_SHIFT: begin
          acc_q <= acc_step;
          rem_q <= rem_step;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state; only in_ready looks at rst/flush.
  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~rst & ~flush;
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

endmodule
